// File: rtl/halut_pkg.sv
// Shared definitions for the HALUT result collector: default tile geometry,
// result word width and the read-side state encoding.
package halut_pkg;

  // Rows per tile (power of two, at least 2).
  localparam int DecoderUnits = 4;

  // FP32 result word width.
  localparam int ResultWidth = 32;

  // Read-side streaming state.
  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } collector_state_t;

endpackage : halut_pkg

// File: rtl/halut_result_collector_if.sv
// Downstream valid/ready stream of the result collector: one result word per
// handshake, tagged with its row index and an end-of-tile marker.
interface halut_result_collector_if #(
  parameter int ResultWidth  = 32,
  parameter int DecAddrWidth = 2
);

  logic [ResultWidth-1:0]  data;
  logic [DecAddrWidth-1:0] m_addr;
  logic                    last;
  logic                    valid;
  logic                    ready;

  // Producer side (the collector).
  modport master (
    output data,
    output m_addr,
    output last,
    output valid,
    input  ready
  );

  // Consumer side.
  modport slave (
    input  data,
    input  m_addr,
    input  last,
    input  valid,
    output ready
  );

endinterface : halut_result_collector_if

// File: rtl/halut_result_bank.sv
// One tile buffer of the result collector: DecoderUnits result registers,
// a per-row filled mask and a full flag. The bank turns full on the write
// that completes the mask; the mask is cleared at that point so the bank is
// ready to collect again as soon as the reader frees it.
module halut_result_bank
  import halut_pkg::*;
#(
  parameter int DecoderUnits = halut_pkg::DecoderUnits,
  parameter int ResultWidth  = halut_pkg::ResultWidth,
  parameter int DecAddrWidth = $clog2(DecoderUnits)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic [DecAddrWidth-1:0] wr_addr_i,
  input  logic [ResultWidth-1:0]  wr_data_i,
  input  logic                    free_i,
  input  logic [DecAddrWidth-1:0] rd_addr_i,
  output logic [ResultWidth-1:0]  rd_data_o,
  output logic                    full_o,
  output logic                    done_o
);

  logic [ResultWidth-1:0]  mem_q [DecoderUnits];
  logic [ResultWidth-1:0]  mem_d [DecoderUnits];
  logic [DecoderUnits-1:0] mask_q, mask_d;
  logic [DecoderUnits-1:0] mask_next;
  logic [DecoderUnits-1:0] row_bit;
  logic                    full_q, full_d;
  logic                    done;

  // Next storage, mask and full flag; a free in the same cycle as the
  // completing write cannot happen because a full bank only accepts writes
  // after being freed, and one write cannot complete a multi-row tile.
  always_comb begin
    mem_d     = mem_q;
    mask_d    = mask_q;
    full_d    = full_q;
    done      = 1'b0;
    row_bit   = '0;
    row_bit[wr_addr_i] = 1'b1;
    mask_next = mask_q | row_bit;
    if (free_i) begin
      full_d = 1'b0;
    end
    if (wr_en_i) begin
      mem_d[wr_addr_i] = wr_data_i;
      if (&mask_next) begin
        mask_d = '0;
        full_d = 1'b1;
        done   = 1'b1;
      end else begin
        mask_d = mask_next;
      end
    end
  end

  // Control state: mask and full flag, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mask_q <= '0;
      full_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
      full_q <= full_d;
    end
  end

  // Result storage: never reset, only meaningful under the mask/full flag.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rd_data_o = mem_q[rd_addr_i];
  assign full_o    = full_q;
  assign done_o    = done;

endmodule : halut_result_bank

// File: rtl/halut_result_collector.sv
// HALUT result collector: gathers per-row results from the multi-decoder
// stage into one of two tile banks (ping-pong) and streams each completed
// tile downstream in row order over a valid/ready handshake. Words arriving
// while the target bank is still full are dropped and flagged on drop_o.
//
// Optional build macro: HALUT_COLLECTOR_DROP_CNT_EN adds drop_cnt_o, a
// 16-bit saturating count of dropped words.
module halut_result_collector
  import halut_pkg::*;
#(
  parameter int DecoderUnits = halut_pkg::DecoderUnits,
  parameter int ResultWidth  = halut_pkg::ResultWidth,
  parameter int DecAddrWidth = $clog2(DecoderUnits)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ResultWidth-1:0]  result_i,
  input  logic                    valid_i,
  input  logic [DecAddrWidth-1:0] m_addr_i,
  halut_result_collector_if.master out_if,
  output logic                    drop_o
`ifdef HALUT_COLLECTOR_DROP_CNT_EN
  ,
  output logic [15:0]             drop_cnt_o
`endif
);

  localparam logic [DecAddrWidth-1:0] LastRow = DecAddrWidth'(DecoderUnits - 1);

  logic [1:0]              bank_full;
  logic [1:0]              bank_done;
  logic [1:0]              bank_free;
  logic [1:0]              bank_wr_en;
  logic [ResultWidth-1:0]  bank_rd_data [2];

  logic                    wr_sel_q, wr_sel_d;
  logic                    rd_sel_q, rd_sel_d;
  logic                    wr_ok;
  logic                    free_now;
  logic                    drop_q, drop_d;

  collector_state_t        state_q, state_d;
  logic [DecAddrWidth-1:0] rd_idx_q, rd_idx_d;
  logic [DecAddrWidth-1:0] m_addr_q, m_addr_d;
  logic [ResultWidth-1:0]  data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;

  // Write side: route the incoming word to the bank being filled. A bank
  // released by the final read handshake this cycle already accepts the
  // write, so the free takes precedence over the full check.
  always_comb begin
    free_now            = (state_q == STREAM) && out_if.ready && last_q;
    bank_free           = '0;
    bank_free[rd_sel_q] = free_now;
    wr_ok               = !bank_full[wr_sel_q] || bank_free[wr_sel_q];
    bank_wr_en          = '0;
    bank_wr_en[wr_sel_q] = valid_i && wr_ok;
    drop_d              = valid_i && !wr_ok;
  end

  // Fill pointer advances on the write that completes the current bank.
  always_comb begin
    wr_sel_d = wr_sel_q ^ bank_done[wr_sel_q];
  end

  // Read FSM next state: wait for a full bank, then walk its rows; the
  // final handshake hands the bank back to the write side.
  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    rd_sel_d = rd_sel_q;
    unique case (state_q)
      IDLE: begin
        if (bank_full[rd_sel_q]) begin
          state_d  = STREAM;
          rd_idx_d = '0;
        end
      end
      STREAM: begin
        if (out_if.ready) begin
          if (last_q) begin
            state_d  = IDLE;
            rd_idx_d = '0;
            rd_sel_d = ~rd_sel_q;
          end else begin
            rd_idx_d = rd_idx_q + DecAddrWidth'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d  = (state_d == STREAM);
    last_d   = (state_d == STREAM) && (rd_idx_d == LastRow);
    m_addr_d = (state_d == STREAM) ? rd_idx_d : '0;
  end

  // Output word: the row about to be presented; zero while idle. The read
  // bank does not change while streaming, so reloading every cycle keeps
  // the word stable under backpressure.
  always_comb begin
    data_d = (state_d == STREAM) ? bank_rd_data[rd_sel_q] : '0;
  end

  // Control and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rd_idx_q <= '0;
      rd_sel_q <= 1'b0;
      wr_sel_q <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      m_addr_q <= '0;
      data_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
      rd_sel_q <= rd_sel_d;
      wr_sel_q <= wr_sel_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      m_addr_q <= m_addr_d;
      data_q   <= data_d;
      drop_q   <= drop_d;
    end
  end

  halut_result_bank #(
    .DecoderUnits (DecoderUnits),
    .ResultWidth  (ResultWidth),
    .DecAddrWidth (DecAddrWidth)
  ) u_bank0 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (bank_wr_en[0]),
    .wr_addr_i (m_addr_i),
    .wr_data_i (result_i),
    .free_i    (bank_free[0]),
    .rd_addr_i (rd_idx_d),
    .rd_data_o (bank_rd_data[0]),
    .full_o    (bank_full[0]),
    .done_o    (bank_done[0])
  );

  halut_result_bank #(
    .DecoderUnits (DecoderUnits),
    .ResultWidth  (ResultWidth),
    .DecAddrWidth (DecAddrWidth)
  ) u_bank1 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (bank_wr_en[1]),
    .wr_addr_i (m_addr_i),
    .wr_data_i (result_i),
    .free_i    (bank_free[1]),
    .rd_addr_i (rd_idx_d),
    .rd_data_o (bank_rd_data[1]),
    .full_o    (bank_full[1]),
    .done_o    (bank_done[1])
  );

`ifdef HALUT_COLLECTOR_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped words.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  assign out_if.valid  = valid_q;
  assign out_if.data   = data_q;
  assign out_if.m_addr = m_addr_q;
  assign out_if.last   = last_q;
  assign drop_o        = drop_q;

endmodule : halut_result_collector

// File: tb/tb_halut_result_collector.sv
// Bench for halut_result_collector (DecoderUnits=4): directed tile traffic,
// a tile-level reference model compared every cycle, and literal spot values.
module tb_halut_result_collector;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] result_i = '0;
  logic        valid_i = 1'b0;
  logic [1:0]  m_addr_i = '0;
  logic        drop_o;
`ifdef HALUT_COLLECTOR_DROP_CNT_EN
  logic [15:0] drop_cnt_o;
`endif

  halut_result_collector_if #(.ResultWidth(32), .DecAddrWidth(2)) out_if ();

  halut_result_collector #(
    .DecoderUnits (4),
    .ResultWidth  (32),
    .DecAddrWidth (2)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .result_i   (result_i),
    .valid_i    (valid_i),
    .m_addr_i   (m_addr_i),
    .out_if     (out_if),
    .drop_o     (drop_o)
`ifdef HALUT_COLLECTOR_DROP_CNT_EN
    ,
    .drop_cnt_o (drop_cnt_o)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- tile-level reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic [1:0]  addr;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  logic [31:0] part [4];
  logic [3:0]  part_mask = '0;
  int          tiles = 0;
  logic        exp_drop = 1'b0;
  int          exp_cnt = 0;
  bit          stall_prev = 1'b0;

  // Compare at the falling edge, then advance the model by what the coming
  // rising edge will see.
  always @(negedge clk) begin
    if (started) begin
      check("drop_o", 32'(drop_o), 32'(exp_drop));
`ifdef HALUT_COLLECTOR_DROP_CNT_EN
      check("drop_cnt_o", 32'(drop_cnt_o), 32'(exp_cnt));
`endif
      if (stall_prev) check("hold_valid", 32'(out_if.valid), 32'd1);
      if (exp_q.size() == 0) check("no_tile_valid", 32'(out_if.valid), 32'd0);
      if (out_if.valid === 1'b1 && exp_q.size() > 0) begin
        check("data_o", out_if.data, exp_q[0].data);
        check("m_addr_o", 32'(out_if.m_addr), 32'(exp_q[0].addr));
        check("last_o", 32'(out_if.last), 32'(exp_q[0].last));
      end else if (out_if.valid !== 1'b1) begin
        check("idle_outs", {out_if.data[28:0], out_if.m_addr, out_if.last},
              32'd0);
      end
    end
    if (!rst_ni) begin
      exp_q.delete();
      part_mask  = '0;
      tiles      = 0;
      exp_drop   = 1'b0;
      exp_cnt    = 0;
      stall_prev = 1'b0;
    end else begin
      stall_prev = (out_if.valid === 1'b1) && !out_if.ready;
      if (out_if.valid === 1'b1 && out_if.ready && exp_q.size() > 0) begin
        if (exp_q[0].last) tiles--;
        void'(exp_q.pop_front());
      end
      exp_drop = 1'b0;
      if (valid_i) begin
        if (tiles == 2) begin
          exp_drop = 1'b1;
          if (exp_cnt < 65535) exp_cnt++;
        end else begin
          part[m_addr_i] = result_i;
          part_mask[m_addr_i] = 1'b1;
          if (part_mask == 4'hF) begin
            for (int r = 0; r < 4; r++) begin
              word_t w;
              w.data = part[r];
              w.addr = 2'(r);
              w.last = (r == 3);
              exp_q.push_back(w);
            end
            tiles++;
            part_mask = '0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    valid_i  = 1'b1;
    m_addr_i = a;
    result_i = d;
    step();
    valid_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    step();
    step();
    rst_ni  = 1'b1;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int r = 0; r < 4; r++) wr(2'(r), base + 32'(r));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    out_if.ready = 1'b0;
    do_reset();
    started = 1'b1;
    check("rst_valid", 32'(out_if.valid), 32'd0);
    check("rst_drop", 32'(drop_o), 32'd0);

    // Single tile with free-flowing ready.
    out_if.ready = 1'b1;
    wr(2'd0, 32'h3F800000);
    wr(2'd1, 32'h40000000);
    wr(2'd2, 32'h40400000);
    wr(2'd3, 32'h40800000);
    check("t1_lat_valid", 32'(out_if.valid), 32'd0);
    step();
    check("t1_w0_valid", 32'(out_if.valid), 32'd1);
    check("t1_w0_data", out_if.data, 32'h3F800000);
    check("t1_w0_last", 32'(out_if.last), 32'd0);
    step();
    check("t1_w1_data", out_if.data, 32'h40000000);
    step();
    check("t1_w2_data", out_if.data, 32'h40400000);
    step();
    check("t1_w3_data", out_if.data, 32'h40800000);
    check("t1_w3_last", 32'(out_if.last), 32'd1);
    step();
    check("t1_end_valid", 32'(out_if.valid), 32'd0);
    repeat (2) step();

    // Tile A stalled while tile B fills, then B follows after one idle cycle.
    do_reset();
    out_if.ready = 1'b0;
    fill(32'hA0);
    step();
    check("t2_a_valid", 32'(out_if.valid), 32'd1);
    fill(32'hB0);
    step();
    check("t2_a_hold", out_if.data, 32'hA0);
    out_if.ready = 1'b1;
    repeat (3) step();
    check("t2_a3_data", out_if.data, 32'hA3);
    step();
    check("t2_gap_valid", 32'(out_if.valid), 32'd0);
    step();
    check("t2_b0_valid", 32'(out_if.valid), 32'd1);
    check("t2_b0_data", out_if.data, 32'hB0);
    repeat (5) step();

    // Both banks full: third tile's first row is dropped.
    do_reset();
    out_if.ready = 1'b0;
    fill(32'hC0);
    fill(32'hD0);
    wr(2'd0, 32'hDEAD);
    check("t3_drop", 32'(drop_o), 32'd1);
`ifdef HALUT_COLLECTOR_DROP_CNT_EN
    check("t3_drop_cnt", 32'(drop_cnt_o), 32'd1);
`endif
    step();
    check("t3_drop_end", 32'(drop_o), 32'd0);
    out_if.ready = 1'b1;
    repeat (12) step();

    // Repeated row overwrites; tile completes only on the missing row.
    do_reset();
    out_if.ready = 1'b1;
    wr(2'd2, 32'h1);
    wr(2'd2, 32'h2);
    wr(2'd0, 32'h10);
    wr(2'd1, 32'h11);
    step();
    check("t4_incomplete", 32'(out_if.valid), 32'd0);
    wr(2'd3, 32'h13);
    step();
    check("t4_w0_data", out_if.data, 32'h10);
    step();
    step();
    check("t4_w2_data", out_if.data, 32'h2);
    check("t4_w2_addr", 32'(out_if.m_addr), 32'd2);
    repeat (3) step();

    // Reset in the middle of a stream.
    do_reset();
    out_if.ready = 1'b1;
    fill(32'h50);
    repeat (3) step();
    check("t5_w2_data", out_if.data, 32'h52);
    rst_ni = 1'b0;
    step();
    check("t5_rst_valid", 32'(out_if.valid), 32'd0);
    rst_ni = 1'b1;
    repeat (3) begin
      step();
      check("t5_quiet", 32'(out_if.valid), 32'd0);
    end
    fill(32'h60);
    step();
    check("t5_fresh_data", out_if.data, 32'h60);
    repeat (5) step();

    // Final handshake of bank 0 coincides with a write into bank 0.
    do_reset();
    out_if.ready = 1'b0;
    fill(32'h70);
    fill(32'h80);
    out_if.ready = 1'b1;
    repeat (3) step();
    check("t6_last_shown", 32'(out_if.last), 32'd1);
    wr(2'd0, 32'h90);
    check("t6_no_drop", 32'(drop_o), 32'd0);
    wr(2'd1, 32'h91);
    wr(2'd2, 32'h92);
    wr(2'd3, 32'h93);
    repeat (12) step();
    check("t6_drained", 32'(out_if.valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_halut_result_collector
